axil_reg_slave: RTL and testbench
=================================

Name: axil_reg_slave

Overview:
- AXI4-Lite responder: the slave-side register bank that the AXI4-Lite master drives with single-beat writes and reads.
- Holds NUM_REGS 32-bit software registers for the PWM controller.
- Exposes the register contents and per-register write strobes to PWM core logic.
- Write channel (AW/W/B) and read channel (AR/R) run independently and concurrently.

Parameters:
- NUM_REGS, 4: number of 32-bit registers; must be ≥1.
- ADDR_WIDTH, 4: AXI address width; must satisfy 2^(ADDR_WIDTH-2) ≥ NUM_REGS.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low
- S_AXI_AWADDR  in  ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  32 / S_AXI_WSTRB  in  4
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  ADDR_WIDTH / S_AXI_ARPROT  in  3 (ignored)
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1
- REG_OUT  out  NUM_REGS*32  register contents; reg k at bits [32k+31:32k]
- WR_PULSE  out  NUM_REGS  one-cycle pulse on the cycle after reg k commits

Behaviour:
- Reset (S_AXI_ARESETN=0, asynchronous):
  - All registers 0; REG_OUT=0, WR_PULSE=0.
  - AWREADY=WREADY=ARREADY=0; BVALID=RVALID=0; BRESP=RRESP=0; RDATA=0.
  - AW and W latches cleared.
- Ready outputs are registered and go to 1 on the first clock edge after deassertion.
- Address decode:
  - idx = ADDR[ADDR_WIDTH-1:2]; ADDR[1:0] ignored.
  - idx ≥ NUM_REGS is out of range.
- Write path, two independent holding latches (AW latch, W latch):
  - AWREADY=1 iff AW latch empty and BVALID=0. WREADY=1 iff W latch empty and BVALID=0.
  - AW and W may arrive in the same cycle or in either order, any gap.
  - Commit happens on the edge after both latches are full. That edge:
    - Registers update when idx is in range.
    - BVALID←1 and BRESP←OKAY(00), or SLVERR(10) with no write when out of range.
    - WR_PULSE[idx]←1 for that one cycle (in range only).
  - Latency: AW+W handshake together at edge N → BVALID and new REG_OUT visible after edge N+1.
  - BVALID and BRESP are held stable until BREADY=1. Latches empty on the B handshake; AWREADY/WREADY reassert the following cycle.
  - Maximum throughput: one write per 3 cycles.
- Read path:
  - ARREADY=1 iff RVALID=0.
  - On an AR handshake at edge N:
    - RDATA←reg[idx] as held before edge N.
    - A write committing on the same edge is not visible.
    - RRESP←OKAY, RVALID←1.
  - Out-of-range read: RDATA=0, RRESP=SLVERR.
  - RVALID, RDATA and RRESP are held until RREADY=1; ARREADY reasserts the cycle after the R handshake.
- Concurrency: read and write paths never stall each other.
- Mid-transaction reset: pending latches, BVALID and RVALID are dropped immediately; no partial write is applied.
- Protocol: VALID outputs never depend combinationally on READY inputs; every output is a flop.

Optional Feature:
- Macro: AXIL_REG_SLAVE_WSTRB_EN
- Defined: byte lane b of the target register is updated only when WSTRB[b]=1. WSTRB=0 still completes with OKAY and WR_PULSE fires.
- Undefined: WSTRB ignored; every write replaces the full 32-bit word.

Test Plan:
- Sequential write/read:
  - Stimulus: write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC; then read all four.
  - Required: BRESP=00 each time; RDATA 0x1..0x4, RRESP=00; REG_OUT[127:96]=0x4; WR_PULSE one cycle per write.
- Skewed channels:
  - Stimulus: AWVALID for addr 0x8 asserted 3 cycles before WVALID (data 0xDEADBEEF).
  - Required: AWREADY drops after the AW handshake; BVALID the cycle after the W handshake; read 0x8 → 0xDEADBEEF.
  - Repeat with W 3 cycles ahead of AW: same result.
- Backpressure:
  - Stimulus: BREADY=0 for 5 cycles after BVALID, with a new AW/W pending.
  - Required: BVALID stable, AWREADY=WREADY=0 throughout; second write commits only after the B handshake.
  - Stimulus: RREADY=0 for 4 cycles.
  - Required: RDATA stable.
- Out of range:
  - Stimulus: with ADDR_WIDTH=5, NUM_REGS=4, write 0x55 to 0x10, then read 0x10.
  - Required: BRESP=10, no REG_OUT change, no WR_PULSE; RDATA=0, RRESP=10.
- Same-edge collision:
  - Stimulus: reg0=0x11; AR on 0x0 on the same edge as a write of 0x22 commits.
  - Required: RDATA=0x11; next read returns 0x22.
- Strobes and reset:
  - With AXIL_REG_SLAVE_WSTRB_EN: reg1=0xAABBCCDD; write 0x11223344 with WSTRB=0x3 → reg1=0xAABB3344.
  - ARESETN pulsed low while BVALID=1 → BVALID=0 immediately; all registers read back 0.

Source files
------------

// File: rtl/axil_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : axil_reg_slave
// Brief    : AXI4-Lite register bank for the PWM controller; exposes register
//            contents and per-register write pulses. Define
//            AXIL_REG_SLAVE_WSTRB_EN for byte-lane strobed writes.
// Revision : 1.0 - initial release
// ============================================================================
module axil_reg_slave #(
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESETN,
    input  logic [ADDR_WIDTH-1:0]  S_AXI_AWADDR,
    input  logic [2:0]             S_AXI_AWPROT,
    input  logic                   S_AXI_AWVALID,
    output logic                   S_AXI_AWREADY,
    input  logic [31:0]            S_AXI_WDATA,
    input  logic [3:0]             S_AXI_WSTRB,
    input  logic                   S_AXI_WVALID,
    output logic                   S_AXI_WREADY,
    output logic [1:0]             S_AXI_BRESP,
    output logic                   S_AXI_BVALID,
    input  logic                   S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]  S_AXI_ARADDR,
    input  logic [2:0]             S_AXI_ARPROT,
    input  logic                   S_AXI_ARVALID,
    output logic                   S_AXI_ARREADY,
    output logic [31:0]            S_AXI_RDATA,
    output logic [1:0]             S_AXI_RRESP,
    output logic                   S_AXI_RVALID,
    input  logic                   S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0] REG_OUT,
    output logic [NUM_REGS-1:0]    WR_PULSE
);

    localparam int         c_IDX_W  = ADDR_WIDTH - 2;
    localparam logic [1:0] c_OKAY   = 2'b00;
    localparam logic [1:0] c_SLVERR = 2'b10;

    logic [31:0]         r_regs [NUM_REGS];

    logic                r_aw_full;
    logic [c_IDX_W-1:0]  r_aw_idx;
    logic                r_w_full;
    logic [31:0]         r_w_data;
    logic                r_awready;
    logic                r_wready;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic [NUM_REGS-1:0] r_wr_pulse;

    logic                r_arready;
    logic                r_rvalid;
    logic [1:0]          r_rresp;
    logic [31:0]         r_rdata;

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_commit;
    logic                w_aw_full_nx;
    logic                w_w_full_nx;
    logic                w_bvalid_nx;
    logic [NUM_REGS-1:0] w_aw_sel;
    logic                w_aw_hit;
    logic [3:0]          w_byte_en;

    logic                w_ar_hs;
    logic                w_rvalid_nx;
    logic [c_IDX_W-1:0]  w_ar_idx;
    logic [31:0]         w_rd_data;
    logic                w_rd_hit;

    logic                w_unused;

`ifdef AXIL_REG_SLAVE_WSTRB_EN
    logic [3:0]          r_w_strb;

    assign w_byte_en = r_w_strb;
    assign w_unused  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
    assign w_byte_en = 4'hF;
    assign w_unused  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         S_AXI_WSTRB};
`endif

    // ------------------------------------------------------------------
    // Write channel: AW and W land in independent latches; the commit
    // fires once both are full and the previous response has been taken.
    // ------------------------------------------------------------------
    assign w_aw_hs      = S_AXI_AWVALID & r_awready;
    assign w_w_hs       = S_AXI_WVALID & r_wready;
    assign w_b_hs       = r_bvalid & S_AXI_BREADY;
    assign w_commit     = r_aw_full & r_w_full & ~r_bvalid;
    assign w_aw_full_nx = w_b_hs ? 1'b0 : (r_aw_full | w_aw_hs);
    assign w_w_full_nx  = w_b_hs ? 1'b0 : (r_w_full | w_w_hs);
    assign w_bvalid_nx  = w_commit | (r_bvalid & ~S_AXI_BREADY);

    always_comb begin
        w_aw_sel = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            w_aw_sel[k] = (int'(r_aw_idx) == k);
        end
    end

    assign w_aw_hit = |w_aw_sel;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_aw_full  <= 1'b0;
            r_aw_idx   <= '0;
            r_w_full   <= 1'b0;
            r_w_data   <= '0;
`ifdef AXIL_REG_SLAVE_WSTRB_EN
            r_w_strb   <= '0;
`endif
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= c_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_aw_full  <= w_aw_full_nx;
            r_w_full   <= w_w_full_nx;
            r_bvalid   <= w_bvalid_nx;
            // Readies are precomputed from next state so they remain pure flops
            r_awready  <= ~w_aw_full_nx & ~w_bvalid_nx;
            r_wready   <= ~w_w_full_nx & ~w_bvalid_nx;
            r_wr_pulse <= w_commit ? w_aw_sel : '0;
            if (w_aw_hs) begin
                r_aw_idx <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
            end
            if (w_w_hs) begin
                r_w_data <= S_AXI_WDATA;
`ifdef AXIL_REG_SLAVE_WSTRB_EN
                r_w_strb <= S_AXI_WSTRB;
`endif
            end
            if (w_commit) begin
                r_bresp <= w_aw_hit ? c_OKAY : c_SLVERR;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_commit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_aw_sel[k] && w_byte_en[b]) begin
                        r_regs[k][8*b +: 8] <= r_w_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel: samples the bank as it stood before the AR edge.
    // ------------------------------------------------------------------
    assign w_ar_hs     = S_AXI_ARVALID & r_arready;
    assign w_rvalid_nx = w_ar_hs | (r_rvalid & ~S_AXI_RREADY);
    assign w_ar_idx    = S_AXI_ARADDR[ADDR_WIDTH-1:2];

    always_comb begin
        w_rd_data = '0;
        w_rd_hit  = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (int'(w_ar_idx) == k) begin
                w_rd_data = r_regs[k];
                w_rd_hit  = 1'b1;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= c_OKAY;
            r_rdata   <= '0;
        end else begin
            r_rvalid  <= w_rvalid_nx;
            r_arready <= ~w_rvalid_nx;
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_hit ? c_OKAY : c_SLVERR;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
        assign REG_OUT[32*k +: 32] = r_regs[k];
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;
    assign WR_PULSE      = r_wr_pulse;

endmodule

`default_nettype wire

// File: tb/tb_axil_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_reg_slave
// Brief    : Directed scoreboard bench for axil_reg_slave (ADDR_WIDTH=5,
//            NUM_REGS=4). Strobe expectations follow AXIL_REG_SLAVE_WSTRB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`define CHK(tag, o, e) chk(tag, 128'(o), 128'(e))

module tb_axil_reg_slave;

    localparam int c_NUM_REGS = 4;
    localparam int c_AW       = 5;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [c_AW-1:0]         awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [31:0]             wdata;
    logic [3:0]              wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [c_AW-1:0]         araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [31:0]             rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    logic [c_NUM_REGS*32-1:0] reg_out;
    logic [c_NUM_REGS-1:0]   wr_pulse;

    typedef struct {
        logic [c_AW-1:0] addr;
        logic [31:0]     data;
        logic [3:0]      strb;
    } wr_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_t;

    wr_t         q_b[$];
    rd_t         q_r[$];
    logic [31:0] m_regs [c_NUM_REGS];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    axil_reg_slave #(
        .NUM_REGS   (c_NUM_REGS),
        .ADDR_WIDTH (c_AW)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .REG_OUT       (reg_out),
        .WR_PULSE      (wr_pulse)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = nw;
`ifdef AXIL_REG_SLAVE_WSTRB_EN
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = strb[b] ? nw[8*b +: 8] : old[8*b +: 8];
        end
`endif
        return r;
    endfunction

    function automatic logic [127:0] model_flat();
        logic [127:0] v;
        for (int k = 0; k < c_NUM_REGS; k++) begin
            v[32*k +: 32] = m_regs[k];
        end
        return v;
    endfunction

    task automatic axi_write(input logic [c_AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        int cyc     = 0;
        q_b.push_back('{addr, data, strb});
        while (!(aw_done && w_done) && cyc < 50) begin
            if (!aw_done && cyc >= aw_dly) begin
                awvalid = 1'b1;
                awaddr  = addr;
            end
            if (!w_done && cyc >= w_dly) begin
                wvalid = 1'b1;
                wdata  = data;
                wstrb  = strb;
            end
            if (awvalid && awready) aw_done = 1'b1;
            if (wvalid && wready)   w_done  = 1'b1;
            @(negedge clk);
            cyc++;
            if (aw_done) begin
                awvalid = 1'b0;
                `CHK("awready_after_aw", awready, 1'b0);
            end
            if (w_done) begin
                wvalid = 1'b0;
                `CHK("wready_after_w", wready, 1'b0);
            end
        end
        `CHK("wr_handshake", aw_done && w_done, 1'b1);
    endtask

    task automatic collect_b(input int exp_lat, input int bready_dly);
        int         n = 0;
        int         idx;
        wr_t        w;
        logic [1:0] exp_resp;
        logic [3:0] exp_pulse;
        while (bvalid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        `CHK("b_arrive", bvalid, 1'b1);
        if (exp_lat >= 0) `CHK("b_latency", n, exp_lat);
        `CHK("b_queue", q_b.size() > 0, 1'b1);
        if (q_b.size() > 0) begin
            w   = q_b.pop_front();
            idx = int'(w.addr[c_AW-1:2]);
            if (idx < c_NUM_REGS) begin
                m_regs[idx] = merge(m_regs[idx], w.data, w.strb);
                exp_resp    = 2'b00;
                exp_pulse   = 4'(1 << idx);
            end else begin
                exp_resp    = 2'b10;
                exp_pulse   = 4'h0;
            end
            `CHK("wr_pulse", wr_pulse, exp_pulse);
            `CHK("bresp", bresp, exp_resp);
            `CHK("reg_out", reg_out, model_flat());
            for (int i = 0; i < bready_dly; i++) begin
                @(negedge clk);
                `CHK("b_hold_valid", bvalid, 1'b1);
                `CHK("b_hold_resp", bresp, exp_resp);
                `CHK("b_hold_awready", awready, 1'b0);
                `CHK("b_hold_wready", wready, 1'b0);
                `CHK("b_hold_reg_out", reg_out, model_flat());
            end
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        `CHK("b_drop", bvalid, 1'b0);
        `CHK("wr_pulse_clear", wr_pulse, 4'h0);
    endtask

    task automatic axi_read(input logic [c_AW-1:0] addr);
        bit done = 1'b0;
        int cyc  = 0;
        int idx;
        idx = int'(addr[c_AW-1:2]);
        if (idx < c_NUM_REGS) q_r.push_back('{m_regs[idx], 2'b00});
        else                  q_r.push_back('{32'h0, 2'b10});
        while (!done && cyc < 50) begin
            arvalid = 1'b1;
            araddr  = addr;
            if (arready) done = 1'b1;
            @(negedge clk);
            cyc++;
        end
        arvalid = 1'b0;
        `CHK("rd_handshake", done, 1'b1);
    endtask

    task automatic collect_r(input int rready_dly);
        int  n = 0;
        rd_t e;
        while (rvalid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        `CHK("r_arrive", rvalid, 1'b1);
        `CHK("r_latency", n, 0);
        `CHK("r_queue", q_r.size() > 0, 1'b1);
        if (q_r.size() > 0) begin
            e = q_r.pop_front();
            for (int i = 0; i < rready_dly; i++) begin
                `CHK("r_hold_data", rdata, e.data);
                `CHK("r_hold_arready", arready, 1'b0);
                @(negedge clk);
            end
            `CHK("rdata", rdata, e.data);
            `CHK("rresp", rresp, e.resp);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        `CHK("r_drop", rvalid, 1'b0);
        `CHK("arready_back", arready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        awaddr  = '0;
        awprot  = 3'b000;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = 4'h0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = '0;
        arprot  = 3'b000;
        arvalid = 1'b0;
        rready  = 1'b0;
        for (int k = 0; k < c_NUM_REGS; k++) m_regs[k] = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        `CHK("rst_awready", awready, 1'b0);
        `CHK("rst_wready", wready, 1'b0);
        `CHK("rst_arready", arready, 1'b0);
        `CHK("rst_bvalid", bvalid, 1'b0);
        `CHK("rst_rvalid", rvalid, 1'b0);
        `CHK("rst_bresp", bresp, 2'b00);
        `CHK("rst_rresp", rresp, 2'b00);
        `CHK("rst_rdata", rdata, 32'h0);
        `CHK("rst_reg_out", reg_out, 128'h0);
        `CHK("rst_wr_pulse", wr_pulse, 4'h0);
        rst_n = 1'b1;
        @(negedge clk);
        `CHK("post_rst_awready", awready, 1'b1);
        `CHK("post_rst_wready", wready, 1'b1);
        `CHK("post_rst_arready", arready, 1'b1);
        n_cmp++;
        if (awready !== 1'b1) begin
            n_err++;
            $error("FAIL post_rst_awready_direct: observed %0h", awready);
        end
        n_cmp++;
        if (arready !== 1'b1) begin
            n_err++;
            $error("FAIL post_rst_arready_direct: observed %0h", arready);
        end

        // Sequential write/read
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0);
            collect_b(1, 0);
        end
        `CHK("reg3_slice", reg_out[127:96], 32'h4);
        n_cmp++;
        if (reg_out[127:96] !== 32'h4) begin
            n_err++;
            $error("FAIL reg3_slice_direct: observed %0h", reg_out[127:96]);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4 * i));
            collect_r(0);
        end

        // Skewed channels, AW first then W first
        axi_write(5'h08, 32'hDEADBEEF, 4'hF, 0, 3);
        collect_b(1, 0);
        axi_read(5'h08);
        collect_r(0);
        axi_write(5'h08, 32'h0, 4'hF, 0, 0);
        collect_b(1, 0);
        axi_write(5'h08, 32'hDEADBEEF, 4'hF, 3, 0);
        collect_b(1, 0);
        axi_read(5'h08);
        collect_r(0);
        `CHK("skew_reg2", reg_out[95:64], 32'hDEADBEEF);
        n_cmp++;
        if (reg_out[95:64] !== 32'hDEADBEEF) begin
            n_err++;
            $error("FAIL skew_reg2_direct: observed %0h", reg_out[95:64]);
        end

        // B backpressure with a second write already pending
        axi_write(5'h04, 32'h12345678, 4'hF, 0, 0);
        awvalid = 1'b1;
        awaddr  = 5'h0C;
        wvalid  = 1'b1;
        wdata   = 32'h9ABCDEF0;
        wstrb   = 4'hF;
        collect_b(1, 5);
        axi_write(5'h0C, 32'h9ABCDEF0, 4'hF, 0, 0);
        collect_b(1, 0);

        // R backpressure
        axi_read(5'h04);
        collect_r(4);

        // Out of range
        axi_write(5'h10, 32'h55, 4'hF, 0, 0);
        collect_b(1, 0);
        axi_read(5'h10);
        collect_r(0);
        axi_read(5'h1C);
        collect_r(0);

        // Read sampled on the same edge as a write commit sees the old value
        axi_write(5'h00, 32'h11, 4'hF, 0, 0);
        collect_b(1, 0);
        axi_write(5'h00, 32'h22, 4'hF, 0, 0);
        axi_read(5'h00);
        collect_b(0, 0);
        collect_r(0);
        axi_read(5'h00);
        collect_r(0);

        // Byte strobes
        axi_write(5'h04, 32'hAABBCCDD, 4'hF, 0, 0);
        collect_b(1, 0);
        axi_write(5'h04, 32'h11223344, 4'h3, 0, 0);
        collect_b(1, 0);
`ifdef AXIL_REG_SLAVE_WSTRB_EN
        `CHK("strobe_reg1", reg_out[63:32], 32'hAABB3344);
`else
        `CHK("strobe_reg1", reg_out[63:32], 32'h11223344);
`endif
        axi_read(5'h04);
        collect_r(0);
        axi_write(5'h04, 32'h5A5A5A5A, 4'h0, 0, 0);
        collect_b(1, 0);
        axi_read(5'h04);
        collect_r(0);

        // Reset while a write response is outstanding
        axi_write(5'h08, 32'h77, 4'hF, 0, 0);
        @(negedge clk);
        `CHK("pre_rst_bvalid", bvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        `CHK("mid_rst_bvalid", bvalid, 1'b0);
        `CHK("mid_rst_rvalid", rvalid, 1'b0);
        `CHK("mid_rst_awready", awready, 1'b0);
        `CHK("mid_rst_wr_pulse", wr_pulse, 4'h0);
        `CHK("mid_rst_reg_out", reg_out, 128'h0);
        n_cmp++;
        if (bvalid !== 1'b0) begin
            n_err++;
            $error("FAIL mid_rst_bvalid_direct: observed %0h", bvalid);
        end
        n_cmp++;
        if (reg_out !== 128'h0) begin
            n_err++;
            $error("FAIL mid_rst_reg_out_direct: observed %0h", reg_out);
        end
        q_b.delete();
        for (int k = 0; k < c_NUM_REGS; k++) m_regs[k] = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4 * i));
            collect_r(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`undef CHK
`default_nettype wire
